// File: rtl/rv_pkg.sv
// Shared RV32I load/store definitions and the data-memory controller state encoding.
package rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RSP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RD   = ST_RD,
    S_WAIT = ST_WAIT,
    S_WR   = ST_WR,
    S_RSP  = ST_RSP
  } state_t;

  // Misaligned halves/words, the reserved size code, and stores with a load-only size.
  function automatic logic access_err(input logic we, input logic [2:0] fn3,
                                      input logic [1:0] addr_lo);
    logic e;
    e = 1'b0;
    if (fn3[1:0] == 2'b11) e = 1'b1;
    if (fn3[1:0] == 2'b01 && addr_lo[0] != 1'b0) e = 1'b1;
    if (fn3[1:0] == 2'b10 && addr_lo != 2'b00) e = 1'b1;
    if (we && !(fn3 == F3_B || fn3 == F3_H || fn3 == F3_W)) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Synchronous single-port word SRAM: one read or write per enabled cycle, read data one cycle later.
module dmem_sram #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller: word reads, SW writes, and read-modify-write for SB/SH through an
// external merge stage. The core stalls whenever the controller is not idle.
//
// Handshake: a request is taken on a rising edge where req_valid=1 and req_ready=1 (IDLE only);
// requests presented while req_ready=0 are dropped, and the core holds req_* stable while stall=1.
// rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err are meaningful only in that cycle.
module dmem_rmw_ctrl
  import rv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_fn3,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   store_data,
  output logic [XLEN-1:0]   rmw_word,
  output logic              stall,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [2:0]        dbg_state
);

  state_t            state, state_d;
  logic              we_q;
  logic [2:0]        fn3_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              acc_err;
  logic              accept;

  // Upper address bits alias onto the SRAM and carry no meaning here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign acc_err = access_err(req_we, req_fn3, req_addr[1:0]);
  assign accept  = (state == S_IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      fn3_q    <= 3'b000;
      addr_q   <= '0;
      err_q    <= 1'b0;
      rmw_word <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        we_q   <= req_we;
        fn3_q  <= req_fn3;
        addr_q <= req_addr[ADDR_W+1:2];
        err_q  <= acc_err;
      end
      if (state == S_WAIT) rmw_word <= mem_rdata;
    end
  end

  always_comb begin
    state_d   = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_err)                       state_d = S_RSP;
          else if (req_we && req_fn3 == F3_W) state_d = S_WR;
          else                               state_d = S_RD;
        end
      end
      S_RD: begin
        mem_en  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only sub-word stores come through the read path; SW went straight to WR.
        state_d = (we_q && fn3_q != F3_W) ? S_WR : S_RSP;
      end
      S_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = store_data;
        state_d   = S_RSP;
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);
  assign rsp_valid = (state == S_RSP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rmw_word;
  assign mem_addr  = addr_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Self-checking bench for dmem_rmw_ctrl with an SRAM, a store-merge stage and a word-array model.
module tb_dmem_rmw_ctrl;
  import rv_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_fn3;
  logic [31:0]   req_addr, store_data, rmw_word, rsp_rdata, mem_wdata, mem_rdata;
  logic          stall, rsp_valid, rsp_err, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    dbg_state;
  logic [31:0]   rs2;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int en_cnt = 0;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   mem_m [0:(1<<AW)-1];

  always #5 clk = ~clk;

  dmem_rmw_ctrl #(.ADDR_W(AW), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_fn3(req_fn3), .req_addr(req_addr), .store_data(store_data), .rmw_word(rmw_word),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  dmem_sram #(.ADDR_W(AW), .XLEN(32)) u_sram (
    .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
  );

  // Store-merge stage: byte lanes of rs2 replace lanes of the old word.
  always_comb begin
    store_data = rmw_word;
    case (req_fn3[1:0])
      2'b00: case (req_addr[1:0])
        2'd0: store_data[7:0]   = rs2[7:0];
        2'd1: store_data[15:8]  = rs2[7:0];
        2'd2: store_data[23:16] = rs2[7:0];
        default: store_data[31:24] = rs2[7:0];
      endcase
      2'b01: if (req_addr[1]) store_data[31:16] = rs2[15:0];
             else             store_data[15:0]  = rs2[15:0];
      default: store_data = rs2;
    endcase
  end

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      en_cnt = en_cnt + 1;
      if (mem_we === 1'b1) begin
        wr_cnt  = wr_cnt + 1;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic exp_err(input logic we, input logic [2:0] f, input logic [31:0] a);
    if (f == 3'd3 || f == 3'd7) return 1'b1;
    if (we && f > 3'd2) return 1'b1;
    if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) return 1'b1;
    if ((f == 3'd2 || f == 3'd6) && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_lat(input logic we, input logic [2:0] f, input logic err);
    if (err) return 1;
    if (!we) return 3;
    return (f == 3'd2) ? 2 : 4;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % (1 << AW));
  endfunction

  function automatic logic [31:0] merged(input logic [31:0] old, input logic [2:0] f,
                                         input logic [31:0] a, input logic [31:0] d);
    int unsigned sh, mask;
    if (f == 3'd2) return d;
    if (f == 3'd0) begin sh = (a % 4) * 8;        mask = 32'hFF;   end
    else           begin sh = ((a % 4) / 2) * 16; mask = 32'hFFFF; end
    return (old & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rdata,
                        output logic err, output int wrs, output int ens, output bit stall_ok);
    int w0, e0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_fn3 = f; req_addr = a; rs2 = d;
    w0 = wr_cnt; e0 = en_cnt; stall_ok = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (stall !== 1'b1) stall_ok = 1'b0;
    end while (rsp_valid !== 1'b1 && lat < 20);
    if (rsp_valid !== 1'b1) lat = -1;
    rdata = rsp_rdata; err = rsp_err;
    req_valid = 1'b0;
    wrs = wr_cnt - w0; ens = en_cnt - e0;
  endtask

  int lat, wrs, ens;
  logic [31:0] rd;
  logic er;
  bit sok;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_fn3 = 3'd0; req_addr = '0; rs2 = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({stall, rsp_valid, rsp_err, mem_en, mem_we, req_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000001",
               {stall, rsp_valid, rsp_err, mem_en, mem_we, req_ready});
    end
    checks++;
    if (rmw_word !== 32'h0 || rsp_rdata !== 32'h0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_data got rmw=%h rdata=%h addr=%h want 0", rmw_word, rsp_rdata, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sw();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      do_req(1'b1, F3_W, 32'(i * 4), v, lat, rd, er, wrs, ens, sok);
      mem_m[i] = v;
    end
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rd, er, wrs, ens, sok);
    mem_m[4] = 32'hDEADBEEF;
    checks++;
    if (lat !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL sw_lat got lat=%0d err=%b want 2/0", lat, er);
    end
    checks++;
    if (wrs !== 1 || ens !== 1 || wr_addr !== 10'd4 || wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_write got wrs=%0d ens=%0d addr=%0d data=%h want 1/1/4/deadbeef",
               wrs, ens, wr_addr, wr_data);
    end
  endtask

  task automatic test_sb();
    do_req(1'b1, F3_W, 32'h10, 32'h11223344, lat, rd, er, wrs, ens, sok);
    mem_m[4] = 32'h11223344;
    do_req(1'b1, F3_B, 32'h10, 32'h000000AA, lat, rd, er, wrs, ens, sok);
    checks++;
    if (lat !== 4 || er !== 1'b0 || rmw_word !== 32'h11223344) begin
      errors++;
      $display("FAIL sb_rmw got lat=%0d err=%b rmw=%h want 4/0/11223344", lat, er, rmw_word);
    end
    checks++;
    if (wrs !== 1 || ens !== 2 || wr_addr !== 10'd4 || wr_data !== 32'h112233AA) begin
      errors++;
      $display("FAIL sb_write got wrs=%0d ens=%0d addr=%0d data=%h want 1/2/4/112233aa",
               wrs, ens, wr_addr, wr_data);
    end
    mem_m[4] = 32'h112233AA;
  endtask

  task automatic test_lw();
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, wrs, ens, sok);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h112233AA || wrs !== 0 || ens !== 1) begin
      errors++;
      $display("FAIL lw got lat=%0d err=%b rdata=%h wrs=%0d ens=%0d want 3/0/112233aa/0/1",
               lat, er, rd, wrs, ens);
    end
  endtask

  task automatic test_misaligned();
    do_req(1'b1, F3_H, 32'h12, 32'h0000BEEF, lat, rd, er, wrs, ens, sok);
    checks++;
    if (lat !== 4 || er !== 1'b0 || wrs !== 1 || wr_data !== 32'hBEEF33AA) begin
      errors++;
      $display("FAIL sh_aligned got lat=%0d err=%b wrs=%0d data=%h want 4/0/1/beef33aa",
               lat, er, wrs, wr_data);
    end
    mem_m[4] = 32'hBEEF33AA;
    do_req(1'b1, F3_H, 32'h13, 32'h1234, lat, rd, er, wrs, ens, sok);
    checks++;
    if (lat !== 1 || er !== 1'b1 || ens !== 0) begin
      errors++; $display("FAIL sh_misaligned got lat=%0d err=%b ens=%0d want 1/1/0", lat, er, ens);
    end
    do_req(1'b0, F3_W, 32'h0E, 32'h0, lat, rd, er, wrs, ens, sok);
    checks++;
    if (lat !== 1 || er !== 1'b1 || ens !== 0) begin
      errors++; $display("FAIL lw_misaligned got lat=%0d err=%b ens=%0d want 1/1/0", lat, er, ens);
    end
    do_req(1'b1, F3_BU, 32'h10, 32'h77, lat, rd, er, wrs, ens, sok);
    checks++;
    if (lat !== 1 || er !== 1'b1 || ens !== 0) begin
      errors++; $display("FAIL store_bad_fn3 got lat=%0d err=%b ens=%0d want 1/1/0", lat, er, ens);
    end
    do_req(1'b0, F3_W, 32'hFFFF_F010, 32'h0, lat, rd, er, wrs, ens, sok);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hBEEF33AA) begin
      errors++;
      $display("FAIL alias_lw got lat=%0d err=%b rdata=%h want 3/0/beef33aa", lat, er, rd);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_fn3 = F3_B; req_addr = 32'h11; rs2 = 32'h55;
    repeat (2) @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy got stall=%b want 1", stall);
    end
    w0 = wr_cnt;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    checks++;
    if ({stall, rsp_valid, rsp_err, mem_en, mem_we} !== 5'b0 || rmw_word !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_out got ctl=%b rmw=%h want 00000/0",
               {stall, rsp_valid, rsp_err, mem_en, mem_we}, rmw_word);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt !== w0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_nowrite got writes=%0d stall=%b want 0/0", wr_cnt - w0, stall);
    end
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, wrs, ens, sok);
    checks++;
    if (rd !== mem_m[4] || er !== 1'b0) begin
      errors++; $display("FAIL rst_mid_word got %h want %h", rd, mem_m[4]);
    end
  endtask

  task automatic test_back_to_back();
    int w0, n;
    bit ok;
    w0 = wr_cnt; ok = 1'b1; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_fn3 = F3_W; req_addr = 32'h20; rs2 = 32'hCAFE0001;
    do begin
      @(negedge clk); n++;
      if (stall !== 1'b1 || req_ready !== 1'b0) ok = 1'b0;
    end while (rsp_valid !== 1'b1 && n < 20);
    checks++;
    if (!ok || n !== 2) begin
      errors++; $display("FAIL b2b_first got lat=%0d stall_ok=%0d want 2/1", n, ok);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got ready=%b stall=%b rsp=%b want 1/0/0", req_ready, stall, rsp_valid);
    end
    n = 0; ok = 1'b1;
    do begin
      @(negedge clk); n++;
      if (stall !== 1'b1) ok = 1'b0;
    end while (rsp_valid !== 1'b1 && n < 20);
    req_valid = 1'b0;
    checks++;
    if (!ok || n !== 2 || wr_cnt - w0 !== 2 || wr_data !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d stall_ok=%0d writes=%0d data=%h want 2/1/2/cafe0001",
               n, ok, wr_cnt - w0, wr_data);
    end
    mem_m[8] = 32'hCAFE0001;
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      logic        we, e;
      logic [2:0]  f;
      logic [31:0] a, d, exp_w;
      int          ix;
      we = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      a  = $urandom & 32'hFFFF_F03F;
      d  = $urandom;
      ix = widx(a);
      e  = exp_err(we, f, a);
      exp_w = merged(mem_m[ix], f, a, d);
      do_req(we, f, a, d, lat, rd, er, wrs, ens, sok);
      checks++;
      if (lat !== exp_lat(we, f, e) || er !== e || !sok) begin
        errors++;
        $display("FAIL rnd_timing op%0d we=%b f=%0d a=%h got lat=%0d err=%b stall_ok=%0d want %0d/%b/1",
                 k, we, f, a, lat, er, sok, exp_lat(we, f, e), e);
      end
      checks++;
      if (wrs !== ((we && !e) ? 1 : 0)) begin
        errors++; $display("FAIL rnd_wrcount op%0d got %0d want %0d", k, wrs, (we && !e) ? 1 : 0);
      end
      if (!e && we) begin
        checks++;
        if (wr_addr !== AW'(ix) || wr_data !== exp_w) begin
          errors++;
          $display("FAIL rnd_store op%0d got addr=%0d data=%h want %0d/%h", k, wr_addr, wr_data, ix, exp_w);
        end
        mem_m[ix] = exp_w;
      end else if (!e) begin
        checks++;
        if (rd !== mem_m[ix]) begin
          errors++; $display("FAIL rnd_load op%0d got %h want %h", k, rd, mem_m[ix]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lw();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
